// File: rtl/axi_rd_arbiter_pkg.sv
// Shared types and constants for the two-requester AXI read arbiter.
// The line geometry must agree with the caches' OFFSET_WIDTH.
package axi_rd_arbiter_pkg;

    localparam int         LINE_WORDS   = 4;
    localparam int         OFFSET_WIDTH = $clog2(LINE_WORDS * 4);
    localparam logic [3:0] ID_I         = 4'd0;
    localparam logic [3:0] ID_D         = 4'd1;
    localparam logic [2:0] SIZE_WORD    = 3'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        DATA = 2'd2
    } rd_fsm_e;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
    } ar_req_t;

    function automatic ar_req_t mk_ar(input logic [3:0] id, input logic [31:0] addr,
                                      input logic [7:0] len, input logic [2:0] size);
        ar_req_t r;
        r.id   = id;
        r.addr = addr;
        r.len  = len;
        r.size = size;
        return r;
    endfunction

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// Cache-side request/return signals plus the AXI AR/R channel of the read arbiter.
// 'master' is the arbiter's view, 'slave' the surrounding caches and interconnect.
interface axi_rd_arbiter_if;

    logic        i_rd_req;
    logic [31:0] i_rd_addr;
    logic        i_rd_rdy;
    logic        i_ret_valid;

    logic        d_rd_req;
    logic        d_rd_type;
    logic [1:0]  d_rd_size;
    logic [31:0] d_rd_addr;
    logic        d_rd_rdy;
    logic        d_ret_valid;

    logic        ret_last;
    logic [31:0] ret_data;

    logic        wb_pending;
    logic [27:0] wb_line;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        input  i_rd_req, i_rd_addr, d_rd_req, d_rd_type, d_rd_size, d_rd_addr,
               wb_pending, wb_line, arready, rid, rdata, rlast, rvalid,
        output i_rd_rdy, i_ret_valid, d_rd_rdy, d_ret_valid, ret_last, ret_data,
               arid, araddr, arlen, arsize, arvalid, rready
    );

    modport slave (
        output i_rd_req, i_rd_addr, d_rd_req, d_rd_type, d_rd_size, d_rd_addr,
               wb_pending, wb_line, arready, rid, rdata, rlast, rvalid,
        input  i_rd_rdy, i_ret_valid, d_rd_rdy, d_ret_valid, ret_last, ret_data,
               arid, araddr, arlen, arsize, arvalid, rready
    );

endinterface

// File: rtl/axi_rd_port_fsm.sv
// Per-requester read tracker: IDLE until granted, AR until the address is
// taken, DATA until the registered last beat for this id.
module axi_rd_port_fsm
    import axi_rd_arbiter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic grant,
    input  logic ar_done,
    input  logic last_beat,
    output logic idle
);

    rd_fsm_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (grant)     state_d = AR;
            AR:      if (ar_done)   state_d = DATA;
            DATA:    if (last_beat) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        idle = (state_q == IDLE);
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI AR/R channel pair between icache and dcache, one read
// outstanding per requester, with read data returned through a registered stage.
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int         LINE_WORDS = axi_rd_arbiter_pkg::LINE_WORDS,
    parameter logic [3:0] ID_I       = axi_rd_arbiter_pkg::ID_I,
    parameter logic [3:0] ID_D       = axi_rd_arbiter_pkg::ID_D
) (
    input logic              clk,
    input logic              reset,
    axi_rd_arbiter_if.master bus
);

    localparam logic [7:0] LINE_LEN   = 8'(LINE_WORDS - 1);
    localparam logic [1:0] STARVE_MAX = 2'd2;

    ar_req_t     ar_q, ar_d;
    logic        ar_valid_q, ar_valid_d;
    logic [1:0]  starve_q, starve_d;
    logic        ret_vld_i_q, ret_vld_i_d;
    logic        ret_vld_d_q, ret_vld_d_d;
    logic        ret_last_q, ret_last_d;
    logic [31:0] ret_data_q, ret_data_d;

    logic        i_idle, d_idle;
    logic        ar_hs, ar_free, hazard;
    logic        i_cand, d_cand, gnt_i, gnt_d;
    logic        beat_i, beat_d;
    logic [31:0] i_line_addr, d_line_addr;
    logic        unused_i_offset;

    assign unused_i_offset = ^bus.i_rd_addr[OFFSET_WIDTH-1:0];

    // A new AR may be loaded into an empty register or one being drained this cycle.
    always_comb begin
        ar_hs       = ar_valid_q && bus.arready;
        ar_free     = !ar_valid_q || bus.arready;
        hazard      = bus.wb_pending && (bus.wb_line == bus.d_rd_addr[31:OFFSET_WIDTH]);
        i_cand      = reset && bus.i_rd_req && i_idle && ar_free;
        d_cand      = reset && bus.d_rd_req && d_idle && !hazard && ar_free;
        gnt_i       = i_cand && (!d_cand || starve_q == STARVE_MAX);
        gnt_d       = d_cand && !gnt_i;
        i_line_addr = {bus.i_rd_addr[31:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
        d_line_addr = {bus.d_rd_addr[31:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
    end

    // Counts consecutive arbitrations the icache lost to the dcache.
    always_comb begin
        starve_d = starve_q;
        if (gnt_i)
            starve_d = '0;
        else if (gnt_d && i_cand && starve_q != STARVE_MAX)
            starve_d = starve_q + 2'd1;
    end

    always_comb begin
        ar_valid_d = ar_valid_q && !bus.arready;
        ar_d       = ar_q;
        if (gnt_d) begin
            ar_valid_d = 1'b1;
            ar_d = bus.d_rd_type ? mk_ar(ID_D, d_line_addr, LINE_LEN, SIZE_WORD)
                                 : mk_ar(ID_D, bus.d_rd_addr, 8'd0, {1'b0, bus.d_rd_size});
        end else if (gnt_i) begin
            ar_valid_d = 1'b1;
            ar_d       = mk_ar(ID_I, i_line_addr, LINE_LEN, SIZE_WORD);
        end
    end

    // Beats for an unknown id or an idle requester are not forwarded.
    always_comb begin
        beat_i      = reset && bus.rvalid && (bus.rid == ID_I) && !i_idle;
        beat_d      = reset && bus.rvalid && (bus.rid == ID_D) && !d_idle;
        ret_vld_i_d = beat_i;
        ret_vld_d_d = beat_d;
        ret_last_d  = (beat_i || beat_d) && bus.rlast;
        ret_data_d  = (beat_i || beat_d) ? bus.rdata : ret_data_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ar_valid_q  <= 1'b0;
            ar_q        <= '0;
            starve_q    <= '0;
            ret_vld_i_q <= 1'b0;
            ret_vld_d_q <= 1'b0;
            ret_last_q  <= 1'b0;
            ret_data_q  <= '0;
        end else begin
            ar_valid_q  <= ar_valid_d;
            ar_q        <= ar_d;
            starve_q    <= starve_d;
            ret_vld_i_q <= ret_vld_i_d;
            ret_vld_d_q <= ret_vld_d_d;
            ret_last_q  <= ret_last_d;
            ret_data_q  <= ret_data_d;
        end
    end

    axi_rd_port_fsm u_fsm_i (
        .clk       (clk),
        .reset     (reset),
        .grant     (gnt_i),
        .ar_done   (ar_hs && ar_q.id == ID_I),
        .last_beat (ret_vld_i_q && ret_last_q),
        .idle      (i_idle)
    );

    axi_rd_port_fsm u_fsm_d (
        .clk       (clk),
        .reset     (reset),
        .grant     (gnt_d),
        .ar_done   (ar_hs && ar_q.id == ID_D),
        .last_beat (ret_vld_d_q && ret_last_q),
        .idle      (d_idle)
    );

    assign bus.i_rd_rdy    = gnt_i;
    assign bus.d_rd_rdy    = gnt_d;
    assign bus.arvalid     = ar_valid_q;
    assign bus.arid        = ar_q.id;
    assign bus.araddr      = ar_q.addr;
    assign bus.arlen       = ar_q.len;
    assign bus.arsize      = ar_q.size;
    assign bus.rready      = reset;
    assign bus.i_ret_valid = ret_vld_i_q;
    assign bus.d_ret_valid = ret_vld_d_q;
    assign bus.ret_last    = ret_last_q;
    assign bus.ret_data    = ret_data_q;

    r_beat_routed_a: assert property (@(posedge clk) disable iff (!reset)
        bus.rvalid |-> (beat_i || beat_d))
        else $error("axi_rd_arbiter: R beat with id %0h dropped", bus.rid);

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: directed scenarios plus random traffic, with an
// outstanding-transaction model checked against the DUT on every cycle.
module tb_axi_rd_arbiter;
    import axi_rd_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    axi_rd_arbiter_if bus();

    axi_rd_arbiter #(.LINE_WORDS(4), .ID_I(4'd0), .ID_D(4'd1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // model: outstanding flags, pending AR, expected registered return
    bit          m_busy[2];
    bit          m_arv;
    logic [3:0]  m_arid;
    logic [31:0] m_araddr;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    int          m_starve;
    bit          m_rv[2];
    bit          m_rlast;
    logic [31:0] m_rdata;
    bit          g_i, g_d;

    // AXI slave: beats still owed per requester (0 = icache, 1 = dcache)
    int          s_left[2];
    logic [31:0] s_data[2];
    logic [31:0] s_base = 32'h0;
    int          ar_pct = 100;
    int          r_pct = 100;
    bit          ar_hold_low = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin : compare
        bit rst, ar_free, hz, i_ok, d_ok, gi, gd;
        int idx;
        if (chk_en) begin
            rst     = !reset;
            ar_free = !m_arv || bus.arready;
            hz      = bus.wb_pending && (bus.wb_line == bus.d_rd_addr[31:4]);
            i_ok    = !rst && bus.i_rd_req && !m_busy[0] && ar_free;
            d_ok    = !rst && bus.d_rd_req && !m_busy[1] && !hz && ar_free;
            gi      = i_ok && (!d_ok || m_starve >= 2);
            gd      = d_ok && !gi;

            chk("i_rd_rdy", bus.i_rd_rdy, gi);
            chk("d_rd_rdy", bus.d_rd_rdy, gd);
            chk("rready", bus.rready, !rst);
            chk("arvalid", bus.arvalid, m_arv);
            if (m_arv) begin
                chk("arid", bus.arid, m_arid);
                chk("araddr", bus.araddr, m_araddr);
                chk("arlen", bus.arlen, m_arlen);
                chk("arsize", bus.arsize, m_arsize);
            end
            chk("i_ret_valid", bus.i_ret_valid, m_rv[0]);
            chk("d_ret_valid", bus.d_ret_valid, m_rv[1]);
            chk("ret_last", bus.ret_last, m_rlast);
            chk("ret_data", bus.ret_data, m_rdata);
            g_i = gi;
            g_d = gd;

            if (rst) begin
                m_busy = '{0, 0};
                m_arv = 0; m_starve = 0;
                m_rv = '{0, 0}; m_rlast = 0; m_rdata = '0;
            end else begin
                if (m_arv && bus.arready) begin
                    idx = (m_arid == ID_D) ? 1 : 0;
                    s_left[idx] = int'(m_arlen) + 1;
                    s_data[idx] = s_base;
                    s_base += 32'h10;
                    m_arv = 0;
                end
                if (m_rv[0] && m_rlast) m_busy[0] = 0;
                if (m_rv[1] && m_rlast) m_busy[1] = 0;
                if (gi) begin
                    m_arv = 1; m_arid = ID_I;
                    m_araddr = {bus.i_rd_addr[31:4], 4'h0};
                    m_arlen = 8'd3; m_arsize = 3'd2;
                    m_busy[0] = 1; m_starve = 0;
                end
                if (gd) begin
                    m_arv = 1; m_arid = ID_D;
                    m_araddr = bus.d_rd_type ? {bus.d_rd_addr[31:4], 4'h0} : bus.d_rd_addr;
                    m_arlen = bus.d_rd_type ? 8'd3 : 8'd0;
                    m_arsize = bus.d_rd_type ? 3'd2 : {1'b0, bus.d_rd_size};
                    m_busy[1] = 1;
                    if (i_ok && m_starve < 2) m_starve++;
                end
                if (bus.rvalid && (bus.rid == ID_I || bus.rid == ID_D)) begin
                    m_rv[0] = (bus.rid == ID_I);
                    m_rv[1] = (bus.rid == ID_D);
                    m_rlast = bus.rlast;
                    m_rdata = bus.rdata;
                end else begin
                    m_rv = '{0, 0};
                    m_rlast = 0;
                end
            end
        end
    end

    // Advance one cycle: retire accepted requests, drive AR ready and one R beat.
    task automatic tick();
        int pick;
        @(posedge clk); #1;
        if (g_i) bus.i_rd_req = 1'b0;
        if (g_d) bus.d_rd_req = 1'b0;
        bus.arready = !ar_hold_low && ($urandom_range(99) < ar_pct);
        bus.rvalid = 1'b0; bus.rlast = 1'b0; bus.rid = 4'd0; bus.rdata = $urandom;
        if (!reset) begin
            s_left = '{0, 0};
        end else if ($urandom_range(99) < r_pct) begin
            pick = -1;
            if (s_left[0] > 0 && s_left[1] > 0) pick = int'($urandom_range(1));
            else if (s_left[0] > 0) pick = 0;
            else if (s_left[1] > 0) pick = 1;
            if (pick >= 0) begin
                bus.rvalid = 1'b1;
                bus.rid    = (pick == 1) ? ID_D : ID_I;
                bus.rdata  = s_data[pick];
                bus.rlast  = (s_left[pick] == 1);
                s_data[pick] += 32'h1;
                s_left[pick]--;
            end
        end
    endtask

    task automatic drain(input string name);
        int k;
        for (k = 0; k < 300; k++) begin
            tick();
            if (!m_busy[0] && !m_busy[1] && !bus.i_rd_req && !bus.d_rd_req) break;
        end
        chk({name, "_drain_timeout"}, k < 300, 1'b1);
    endtask

    initial begin : wdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int nb, nd, lastn;
        logic [31:0] rnd;
        bus.i_rd_req = 0; bus.i_rd_addr = '0;
        bus.d_rd_req = 0; bus.d_rd_type = 0; bus.d_rd_size = 0; bus.d_rd_addr = '0;
        bus.wb_pending = 0; bus.wb_line = '0;
        bus.arready = 0; bus.rvalid = 0; bus.rid = 0; bus.rdata = 0; bus.rlast = 0;
        s_left = '{0, 0};

        // reset state
        @(posedge clk); #1; chk_en = 1'b1;
        tick(); tick();
        @(negedge clk);
        chk("rst_arvalid", bus.arvalid, 1'b0);
        chk("rst_rready", bus.rready, 1'b0);
        chk("rst_ret", {bus.i_ret_valid, bus.d_ret_valid, bus.ret_last}, 3'b000);
        chk("rst_data", bus.ret_data, 32'h0);
        reset = 1'b1;
        tick();

        // single icache line refill
        s_base = 32'hA0;
        bus.i_rd_addr = 32'h1c00_0040; bus.i_rd_req = 1;
        @(negedge clk); chk("t1_i_rdy", bus.i_rd_rdy, 1'b1);
        tick();
        @(negedge clk);
        chk("t1_arvalid", bus.arvalid, 1'b1);
        chk("t1_araddr", bus.araddr, 32'h1c00_0040);
        chk("t1_arlen", bus.arlen, 32'd3);
        chk("t1_arid", bus.arid, 32'd0);
        nb = 0;
        for (int k = 0; k < 12; k++) begin
            tick(); @(negedge clk);
            if (bus.i_ret_valid) begin
                chk("t1_data", bus.ret_data, 32'hA0 + nb);
                nb++;
                chk("t1_last", bus.ret_last, nb == 4);
            end
        end
        chk("t1_beats", nb, 32'd4);
        drain("t1");

        // simultaneous requests: dcache first, interleaved returns
        r_pct = 60;
        bus.i_rd_addr = 32'h1000_0008; bus.i_rd_req = 1;
        bus.d_rd_type = 1; bus.d_rd_addr = 32'h2000_0010; bus.d_rd_req = 1;
        @(negedge clk);
        chk("t2_d_rdy", bus.d_rd_rdy, 1'b1);
        chk("t2_i_rdy", bus.i_rd_rdy, 1'b0);
        tick(); @(negedge clk);
        chk("t2_i_rdy_next", bus.i_rd_rdy, 1'b1);
        chk("t2_arid_d", bus.arid, 32'd1);
        tick(); @(negedge clk);
        chk("t2_arid_i", bus.arid, 32'd0);
        chk("t2_araddr_i", bus.araddr, 32'h1000_0000);
        nb = 0; nd = 0;
        for (int k = 0; k < 60; k++) begin
            tick(); @(negedge clk);
            if (bus.i_ret_valid) nb++;
            if (bus.d_ret_valid) nd++;
        end
        chk("t2_i_beats", nb, 32'd4);
        chk("t2_d_beats", nd, 32'd4);
        drain("t2");

        // uncached halfword read
        r_pct = 100;
        bus.d_rd_type = 0; bus.d_rd_size = 2'd1; bus.d_rd_addr = 32'hbfaf_8002; bus.d_rd_req = 1;
        @(negedge clk); chk("t3_d_rdy", bus.d_rd_rdy, 1'b1);
        tick(); @(negedge clk);
        chk("t3_arlen", bus.arlen, 32'd0);
        chk("t3_arsize", bus.arsize, 32'd1);
        chk("t3_araddr", bus.araddr, 32'hbfaf_8002);
        nd = 0; lastn = 0;
        for (int k = 0; k < 8; k++) begin
            tick(); @(negedge clk);
            if (bus.d_ret_valid) begin nd++; if (bus.ret_last) lastn++; end
        end
        chk("t3_beats", nd, 32'd1);
        chk("t3_last", lastn, 32'd1);
        drain("t3");

        // write-back hazard holds the dcache off
        bus.wb_pending = 1; bus.wb_line = 28'h000_0010;
        bus.d_rd_type = 1; bus.d_rd_addr = 32'h0000_0100; bus.d_rd_req = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); chk("t4_d_held", bus.d_rd_rdy, 1'b0);
            tick();
        end
        bus.wb_pending = 0;
        @(negedge clk); chk("t4_d_rdy", bus.d_rd_rdy, 1'b1);
        drain("t4");

        // AR stall keeps fields stable and blocks the next grant
        ar_hold_low = 1; tick();
        bus.i_rd_addr = 32'h3000_0020; bus.i_rd_req = 1;
        @(negedge clk); chk("t5_i_rdy", bus.i_rd_rdy, 1'b1);
        tick();
        bus.d_rd_type = 1; bus.d_rd_addr = 32'h4000_0000; bus.d_rd_req = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t5_araddr", bus.araddr, 32'h3000_0020);
            chk("t5_arvalid", bus.arvalid, 1'b1);
            chk("t5_d_wait", bus.d_rd_rdy, 1'b0);
            chk("t5_i_rdy", bus.i_rd_rdy, 1'b0);
            tick();
        end
        ar_hold_low = 0; bus.arready = 1;
        @(negedge clk); chk("t5_d_rdy", bus.d_rd_rdy, 1'b1);
        tick(); @(negedge clk);
        chk("t5_arid", bus.arid, 32'd1);
        chk("t5_araddr_d", bus.araddr, 32'h4000_0000);
        drain("t5");

        // reset mid-burst, then a fresh request
        bus.i_rd_addr = 32'h5000_0000; bus.i_rd_req = 1;
        nb = 0;
        for (int k = 0; k < 20 && nb < 2; k++) begin
            tick(); @(negedge clk);
            if (bus.i_ret_valid) nb++;
        end
        chk("t6_two_beats", nb, 32'd2);
        tick(); reset = 0; bus.i_rd_req = 0; bus.d_rd_req = 0;
        tick(); @(negedge clk);
        chk("t6_rdy", {bus.i_rd_rdy, bus.d_rd_rdy}, 2'b00);
        chk("t6_ret", {bus.i_ret_valid, bus.d_ret_valid, bus.ret_last}, 3'b000);
        chk("t6_arvalid", bus.arvalid, 1'b0);
        chk("t6_rready", bus.rready, 1'b0);
        tick(); reset = 1;
        tick();
        bus.i_rd_addr = 32'h6000_0000; bus.i_rd_req = 1;
        @(negedge clk); chk("t6_fresh", bus.i_rd_rdy, 1'b1);
        drain("t6");

        // random traffic
        ar_pct = 70; r_pct = 60;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (!bus.i_rd_req && $urandom_range(3) == 0) begin
                bus.i_rd_addr = $urandom; bus.i_rd_req = 1;
            end
            if (!bus.d_rd_req && $urandom_range(3) == 0) begin
                rnd = $urandom;
                bus.d_rd_type = $urandom_range(1);
                bus.d_rd_size = 2'($urandom_range(2));
                bus.d_rd_addr = bus.d_rd_type ? {rnd[31:4], 4'h0} : rnd;
                bus.d_rd_req = 1;
            end
            if ($urandom_range(7) == 0) begin
                rnd = $urandom;
                bus.wb_pending = $urandom_range(1);
                bus.wb_line = ($urandom_range(1) == 1) ? bus.d_rd_addr[31:4] : rnd[27:0];
            end
        end
        bus.wb_pending = 0; ar_pct = 100; r_pct = 100;
        drain("rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
